data_mem_responder: RTL and testbench

Memory-side responder for the core's load/store port. It accepts one load or store request at a time over a valid/ready handshake. It inserts a programmable number of wait states, then performs a byte-, half- or word-sized access on an internal word-organised SRAM, and returns the result over a valid/ready response channel. It sits between the datapath's ALU-result/RD2/funct3 outputs and the data store, and is the multi-cycle replacement for the single-cycle data memory.

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_lane_unit.sv | 78 +++++++
 rtl/data_mem_responder.sv | 110 +++++++++++
 tb/tb_data_mem_responder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory responder: FSM states,
// RV32I load/store funct3 codes and the access-size type.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/dmem_lane_unit.sv
// Combinational lane logic: funct3 decode, byte enables, store merge and load extension.
// Optional DMEM_MISALIGN_TRAP_EN flags misaligned half/word accesses as errors.
module dmem_lane_unit
  import dmem_pkg::*;
#(
  parameter int BITSIZE = 32
) (
  input  logic               write,
  input  logic [2:0]         funct3,
  input  logic [1:0]         offset,
  input  logic [BITSIZE-1:0] wdata,
  input  logic [BITSIZE-1:0] old_word,
  output logic [BITSIZE/8-1:0] be,
  output logic [BITSIZE-1:0] merged,
  output logic [BITSIZE-1:0] load_data,
  output logic               err
);

  size_t size;
  logic  is_unsigned;
  logic  illegal;
  logic  misaligned;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [BITSIZE-1:0] wrep;

  always_comb begin
    size        = SZ_W;
    is_unsigned = 1'b0;
    illegal     = 1'b0;
    case (funct3)
      F3_B:  size = SZ_B;
      F3_H:  size = SZ_H;
      F3_W:  size = SZ_W;
      F3_BU: begin size = SZ_B; is_unsigned = 1'b1; illegal = write; end
      F3_HU: begin size = SZ_H; is_unsigned = 1'b1; illegal = write; end
      default: illegal = 1'b1;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misaligned = (size == SZ_H && offset[0]) || (size == SZ_W && offset != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign err = illegal | misaligned;

  // Offset bits below the access size are simply not used when not trapping.
  always_comb begin
    be        = '0;
    wrep      = wdata;
    byte_v    = old_word[{offset, 3'b000} +: 8];
    half_v    = old_word[{offset[1], 4'b0000} +: 16];
    load_data = old_word;
    case (size)
      SZ_B: begin
        be[offset] = 1'b1;
        wrep       = {(BITSIZE/8){wdata[7:0]}};
        load_data  = is_unsigned ? {{(BITSIZE-8){1'b0}}, byte_v}
                                 : {{(BITSIZE-8){byte_v[7]}}, byte_v};
      end
      SZ_H: begin
        be[{offset[1], 1'b0}] = 1'b1;
        be[{offset[1], 1'b1}] = 1'b1;
        wrep       = {(BITSIZE/16){wdata[15:0]}};
        load_data  = is_unsigned ? {{(BITSIZE-16){1'b0}}, half_v}
                                 : {{(BITSIZE-16){half_v[15]}}, half_v};
      end
      default: be = '1;
    endcase
    if (err) be = '0;
    merged = old_word;
    for (int unsigned i = 0; i < BITSIZE/8; i++)
      if (be[i]) merged[8*i +: 8] = wrep[8*i +: 8];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory responder: valid/ready request, WAIT_STATES delay, one-cycle
// SRAM access, held response. Optional macro: DMEM_MISALIGN_TRAP_EN.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int BITSIZE     = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [2:0]         req_funct3,
  input  logic [BITSIZE-1:0] req_addr,
  input  logic [BITSIZE-1:0] req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [BITSIZE-1:0] rsp_rdata,
  output logic               rsp_err,
  output logic               busy
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_t state;
  logic [3:0] cnt;
  logic       r_write;
  logic [2:0] r_funct3;
  logic [IDX_W+1:0] r_addr;
  logic [BITSIZE-1:0] r_wdata;

  logic [BITSIZE-1:0] mem [DEPTH_WORDS];
  logic [IDX_W-1:0]   idx;
  logic [BITSIZE-1:0] old_word;
  logic [BITSIZE-1:0] merged;
  logic [BITSIZE-1:0] load_data;
  logic [BITSIZE/8-1:0] be;
  logic lane_err;
  logic unused_addr_bits;

  // Upper address bits are dropped so accesses wrap modulo the SRAM size.
  assign unused_addr_bits = ^req_addr[BITSIZE-1:IDX_W+2] ^ ^be;

  assign idx      = r_addr[IDX_W+1:2];
  assign old_word = mem[idx];

  dmem_lane_unit #(.BITSIZE(BITSIZE)) u_lane (
    .write     (r_write),
    .funct3    (r_funct3),
    .offset    (r_addr[1:0]),
    .wdata     (r_wdata),
    .old_word  (old_word),
    .be        (be),
    .merged    (merged),
    .load_data (load_data),
    .err       (lane_err)
  );

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // SRAM write shares the reset-guarded block so a reset on the ACCESS-exit edge suppresses it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      r_write   <= 1'b0;
      r_funct3  <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            r_write  <= req_write;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr[IDX_W+1:0];
            r_wdata  <= req_wdata;
            cnt      <= 4'(WAIT_STATES);
            state    <= (WAIT_STATES > 0) ? WAIT : ACCESS;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= ACCESS;
        end
        ACCESS: begin
          if (r_write && !lane_err) mem[idx] <= merged;
          rsp_valid <= 1'b1;
          rsp_err   <= lane_err;
          rsp_rdata <= (r_write || lane_err) ? '0 : load_data;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a byte-array reference model.
module tb_data_mem_responder;

  localparam int WS    = 2;
  localparam int DEPTH = 256;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  bit [7:0] ref_mem [DEPTH*4];

  bit [31:0] rd, exp_rd;
  bit        er, exp_er, uns, idl;
  int        lat;

  data_mem_responder #(.BITSIZE(32), .DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clock = ~clock;

  // Reference: little-endian byte memory, access size from funct3, wrap modulo SRAM size.
  function automatic void model(input bit w, input bit [2:0] f3, input bit [31:0] a,
                                input bit [31:0] wd, output bit [31:0] r, output bit e);
    int unsigned n, base;
    bit sx, legal;
    bit [31:0] v;
    n = 4; sx = 0; legal = 1;
    case (f3)
      3'd0: begin n = 1; sx = 1; end
      3'd1: begin n = 2; sx = 1; end
      3'd2: n = 4;
      3'd4: begin n = 1; legal = !w; end
      3'd5: begin n = 2; legal = !w; end
      default: legal = 0;
    endcase
`ifdef DMEM_MISALIGN_TRAP_EN
    if (a % n != 0) legal = 0;
`endif
    r = 0;
    e = !legal;
    if (!legal) return;
    base = a % (DEPTH*4);
    base = base - base % n;
    if (w) begin
      for (int unsigned i = 0; i < n; i++) ref_mem[base+i] = 8'(wd >> (8*i));
    end else begin
      v = 0;
      for (int unsigned i = 0; i < n; i++) v = v | (32'(ref_mem[base+i]) << (8*i));
      if (sx && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      r = v;
    end
  endfunction

  task automatic do_req(input bit w, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd,
                        input int hold, output bit [31:0] r, output bit e, output int l,
                        output bit unstable, output bit idle_after);
    int n;
    @(negedge clock);
    req_valid = 1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    rsp_ready = (hold == 0);
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clock); n++; end
    @(posedge clock); #1;
    req_valid = 0; req_write = ~w; req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    l = 0;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clock); #1;
      if (rsp_valid) begin l = i; break; end
    end
    r = rsp_rdata; e = rsp_err; unstable = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      if (rsp_valid !== 1 || rsp_rdata !== r || rsp_err !== e || req_ready !== 0) unstable = 1;
    end
    rsp_ready = 1;
    @(posedge clock); #1;
    idle_after = (rsp_valid === 0) && (req_ready === 1) && (busy === 0);
    rsp_ready = 0;
  endtask

  task automatic test_reset;
    total_cnt++;
    if ({req_ready, rsp_valid, rsp_err, busy} !== 4'b1000 || rsp_rdata !== 32'h0)
      $display("FAIL reset_state ready/valid/err/busy=%b rdata=%h need 1000/0",
               {req_ready, rsp_valid, rsp_err, busy}, rsp_rdata);
    else pass_cnt++;
  endtask

  task automatic test_fill;
    bit [31:0] wd;
    for (int i = 0; i < 32; i++) begin
      wd = $urandom;
      do_req(1, 3'd2, 32'(i*4), wd, 0, rd, er, lat, uns, idl);
      model(1, 3'd2, 32'(i*4), wd, exp_rd, exp_er);
      total_cnt++;
      if (er !== exp_er || rd !== exp_rd || lat != WS+1)
        $display("FAIL fill word %0d err=%b rdata=%h lat=%0d need %b/%h/%0d", i, er, rd, lat, exp_er, exp_rd, WS+1);
      else pass_cnt++;
    end
  endtask

  task automatic test_word;
    do_req(1, 3'd2, 32'h10, 32'hDEADBEEF, 0, rd, er, lat, uns, idl);
    total_cnt++;
    if (er !== 0 || rd !== 0 || lat != WS+1)
      $display("FAIL sw_10 err=%b rdata=%h lat=%0d need 0/0/%0d", er, rd, lat, WS+1);
    else pass_cnt++;
    model(1, 3'd2, 32'h10, 32'hDEADBEEF, exp_rd, exp_er);
    do_req(0, 3'd2, 32'h10, 0, 0, rd, er, lat, uns, idl);
    total_cnt++;
    if (er !== 0 || rd !== 32'hDEADBEEF || lat != WS+1)
      $display("FAIL lw_10 err=%b rdata=%h lat=%0d need 0/deadbeef/%0d", er, rd, lat, WS+1);
    else pass_cnt++;
  endtask

  task automatic test_byte_ext;
    do_req(1, 3'd0, 32'h21, 32'h1234_5680, 0, rd, er, lat, uns, idl);
    model(1, 3'd0, 32'h21, 32'h1234_5680, exp_rd, exp_er);
    do_req(0, 3'd0, 32'h21, 0, 0, rd, er, lat, uns, idl);
    total_cnt++;
    if (rd !== 32'hFFFF_FF80 || er !== 0) $display("FAIL lb_21 rdata=%h err=%b need ffffff80/0", rd, er);
    else pass_cnt++;
    do_req(0, 3'd4, 32'h21, 0, 0, rd, er, lat, uns, idl);
    total_cnt++;
    if (rd !== 32'h0000_0080 || er !== 0) $display("FAIL lbu_21 rdata=%h err=%b need 00000080/0", rd, er);
    else pass_cnt++;
    model(0, 3'd2, 32'h20, 0, exp_rd, exp_er);
    do_req(0, 3'd2, 32'h20, 0, 0, rd, er, lat, uns, idl);
    total_cnt++;
    if (rd !== exp_rd || exp_rd[15:8] !== 8'h80) $display("FAIL lw_20_lanes rdata=%h need %h", rd, exp_rd);
    else pass_cnt++;
  endtask

  task automatic test_backpressure;
    model(0, 3'd2, 32'h10, 0, exp_rd, exp_er);
    do_req(0, 3'd2, 32'h10, 0, 5, rd, er, lat, uns, idl);
    total_cnt++;
    if (rd !== exp_rd || lat != WS+1) $display("FAIL bp_data rdata=%h lat=%0d need %h/%0d", rd, lat, exp_rd, WS+1);
    else pass_cnt++;
    total_cnt++;
    if (uns !== 0) $display("FAIL bp_stable unstable=%b need 0", uns);
    else pass_cnt++;
    total_cnt++;
    if (idl !== 1) $display("FAIL bp_release idle_after=%b need 1", idl);
    else pass_cnt++;
  endtask

  task automatic test_illegal;
    do_req(1, 3'd3, 32'h40, 32'hCAFE_F00D, 0, rd, er, lat, uns, idl);
    total_cnt++;
    if (er !== 1 || rd !== 0 || lat != WS+1)
      $display("FAIL st_f3_011 err=%b rdata=%h lat=%0d need 1/0/%0d", er, rd, lat, WS+1);
    else pass_cnt++;
    do_req(1, 3'd5, 32'h40, 32'hCAFE_F00D, 0, rd, er, lat, uns, idl);
    total_cnt++;
    if (er !== 1 || rd !== 0) $display("FAIL st_f3_101 err=%b rdata=%h need 1/0", er, rd);
    else pass_cnt++;
    model(0, 3'd2, 32'h40, 0, exp_rd, exp_er);
    do_req(0, 3'd2, 32'h40, 0, 0, rd, er, lat, uns, idl);
    total_cnt++;
    if (er !== 0 || rd !== exp_rd) $display("FAIL lw_40_after_illegal rdata=%h err=%b need %h/0", rd, er, exp_rd);
    else pass_cnt++;
    do_req(0, 3'd7, 32'h40, 0, 0, rd, er, lat, uns, idl);
    total_cnt++;
    if (er !== 1 || rd !== 0) $display("FAIL ld_f3_111 err=%b rdata=%h need 1/0", er, rd);
    else pass_cnt++;
  endtask

  task automatic test_misalign;
    model(0, 3'd1, 32'h3, 0, exp_rd, exp_er);
    do_req(0, 3'd1, 32'h3, 0, 0, rd, er, lat, uns, idl);
    total_cnt++;
    if (er !== exp_er || rd !== exp_rd || lat != WS+1)
      $display("FAIL lh_3 err=%b rdata=%h lat=%0d need %b/%h/%0d", er, rd, lat, exp_er, exp_rd, WS+1);
    else pass_cnt++;
    do_req(1, 3'd2, 32'h6, 32'h0BAD_CAFE, 0, rd, er, lat, uns, idl);
    model(1, 3'd2, 32'h6, 32'h0BAD_CAFE, exp_rd, exp_er);
    total_cnt++;
    if (er !== exp_er) $display("FAIL sw_6 err=%b need %b", er, exp_er);
    else pass_cnt++;
    model(0, 3'd2, 32'h4, 0, exp_rd, exp_er);
    do_req(0, 3'd2, 32'h4, 0, 0, rd, er, lat, uns, idl);
    total_cnt++;
    if (rd !== exp_rd) $display("FAIL lw_4_after_sw_6 rdata=%h need %h", rd, exp_rd);
    else pass_cnt++;
  endtask

  task automatic test_reset_midop;
    @(negedge clock);
    req_valid = 1; req_write = 1; req_funct3 = 3'd2; req_addr = 32'h8; req_wdata = 32'h1234_5678;
    @(posedge clock); #1;
    req_valid = 0;
    @(posedge clock); #1;
    total_cnt++;
    if (busy !== 1) $display("FAIL midop_busy busy=%b need 1", busy);
    else pass_cnt++;
    reset = 1; #1;
    total_cnt++;
    if ({req_ready, rsp_valid, rsp_err, busy} !== 4'b1000 || rsp_rdata !== 0)
      $display("FAIL midop_reset ready/valid/err/busy=%b rdata=%h need 1000/0",
               {req_ready, rsp_valid, rsp_err, busy}, rsp_rdata);
    else pass_cnt++;
    @(negedge clock); reset = 0;
    model(0, 3'd2, 32'h8, 0, exp_rd, exp_er);
    do_req(0, 3'd2, 32'h8, 0, 0, rd, er, lat, uns, idl);
    total_cnt++;
    if (rd !== exp_rd || er !== 0) $display("FAIL lw_8_after_abort rdata=%h need %h", rd, exp_rd);
    else pass_cnt++;
    // Abort while in ACCESS, with reset rising just before the ACCESS-exit edge.
    @(negedge clock);
    req_valid = 1; req_write = 1; req_funct3 = 3'd2; req_addr = 32'hC; req_wdata = 32'hA5A5_5A5A;
    @(posedge clock); #1;
    req_valid = 0;
    repeat (WS) @(posedge clock);
    #9 reset = 1;
    #1;
    total_cnt++;
    if (rsp_valid !== 0 || busy !== 0) $display("FAIL access_reset valid=%b busy=%b need 0/0", rsp_valid, busy);
    else pass_cnt++;
    @(negedge clock); reset = 0;
    model(0, 3'd2, 32'hC, 0, exp_rd, exp_er);
    do_req(0, 3'd2, 32'hC, 0, 0, rd, er, lat, uns, idl);
    total_cnt++;
    if (rd !== exp_rd) $display("FAIL lw_c_after_abort rdata=%h need %h", rd, exp_rd);
    else pass_cnt++;
  endtask

  task automatic test_random;
    bit [31:0] r, a, wd;
    bit w;
    bit [2:0] f3;
    int hold;
    for (int i = 0; i < 60; i++) begin
      r = $urandom; wd = $urandom;
      a = {r[31:10], 3'b000, r[6:0]};
      w = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      hold = $urandom_range(0, 2);
      do_req(w, f3, a, wd, hold, rd, er, lat, uns, idl);
      model(w, f3, a, wd, exp_rd, exp_er);
      total_cnt++;
      if (rd !== exp_rd || er !== exp_er || lat != WS+1 || uns !== 0 || idl !== 1)
        $display("FAIL rand%0d w=%b f3=%0d a=%h rdata=%h err=%b lat=%0d st=%b id=%b need %h/%b/%0d/0/1",
                 i, w, f3, a, rd, er, lat, uns, idl, exp_rd, exp_er, WS+1);
      else pass_cnt++;
    end
  endtask

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock); reset = 0;
    #1;
    test_reset;
    test_fill;
    test_word;
    test_byte_ext;
    test_backpressure;
    test_illegal;
    test_misalign;
    test_reset_midop;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
